// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the ISCAS89 wrapper BIST driver.
package iscas_bist_pkg;

    // One state per cycle: each pattern walks SETUP -> PULSE -> CAPTURE.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        CAPTURE,
        DONE
    } bist_state_e;

    // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting register: bits 7,5,4,3.
    localparam logic [7:0] TAP_MASK = 8'hB8;

    // Bit positions inside the wrapper's io_in bus.
    localparam int unsigned DUT_CK = 0;
    localparam int unsigned G0     = 1;
    localparam int unsigned G1     = 2;
    localparam int unsigned G2     = 3;
    localparam int unsigned GND    = 4;
    localparam int unsigned VDD    = 5;

    // Supply pins at their rails, DUT clock low, stimulus zero.
    localparam logic [7:0] DUT_IN_RST = 8'h20;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    function automatic logic [7:0] fix_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

    // Build the io_in word for a given stimulus (low three LFSR bits) and DUT clock level.
    function automatic logic [7:0] stim_word(input logic [7:0] lfsr, input logic ck);
        logic [7:0] w;
        w         = DUT_IN_RST;
        w[G0]     = lfsr[0];
        w[G1]     = lfsr[1];
        w[G2]     = lfsr[2];
        w[DUT_CK] = ck;
        return w;
    endfunction

endpackage

// File: rtl/bist_shreg8.sv
// 8-bit left-shifting register with tap-mask parity feedback and a parallel XOR input.
// With par_in tied to zero it is a Fibonacci LFSR; with response data it is a MISR.
module bist_shreg8
    import iscas_bist_pkg::*;
#(
    parameter logic [7:0] TAPS    = TAP_MASK,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       shift,
    input  logic [7:0] par_in,
    output logic [7:0] q,
    output logic [7:0] q_next
);

    // Next value if a shift happens this cycle; exposed so the parent can look ahead.
    always_comb begin
        q_next = {q[6:0], ^(q & TAPS)} ^ par_in;
    end

    // Reset beats load, load beats shift.
    always_ff @(posedge CK) begin
        if (RST) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/iscas_bist_driver.sv
// Pin-side self-test harness for the 8-bit ISCAS89 wrapper: LFSR stimulus out, MISR compaction in.
module iscas_bist_driver
    import iscas_bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 255,
    parameter logic [7:0]  LFSR_SEED  = 8'h01,
    parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] dut_out,
    output logic [7:0] dut_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature,
    output logic [7:0] pat_cnt
);

    localparam logic [7:0] SEED_EFF = fix_seed(LFSR_SEED);
    // Index of the final pattern; pat_cnt never needs to reach 256.
    localparam logic [7:0] LAST_IDX = 8'(N_PATTERNS - 1);

    bist_state_e state;

    logic       run_init;
    logic       capture;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_nx;
    logic [7:0] misr_nx;
    logic       unused_bits;

    // A run (re)starts only from the two resting states; start is ignored while busy.
    always_comb begin
        run_init = start && ((state == IDLE) || (state == DONE));
        capture  = (state == CAPTURE);
    end

    // io_out[7:6] carry nothing; only the low LFSR bits reach the pins.
    assign unused_bits = ^{dut_out[7:6], lfsr_q, lfsr_nx[7:3]};

    bist_shreg8 #(
        .TAPS    (TAP_MASK),
        .RST_VAL (SEED_EFF)
    ) u_lfsr (
        .CK       (CK),
        .RST      (RST),
        .load     (run_init),
        .load_val (SEED_EFF),
        .shift    (capture),
        .par_in   (8'h00),
        .q        (lfsr_q),
        .q_next   (lfsr_nx)
    );

    bist_shreg8 #(
        .TAPS    (TAP_MASK),
        .RST_VAL (8'h00)
    ) u_misr (
        .CK       (CK),
        .RST      (RST),
        .load     (run_init),
        .load_val (8'h00),
        .shift    (capture),
        .par_in   ({2'b00, dut_out[5:0]}),
        .q        (signature),
        .q_next   (misr_nx)
    );

    // Sequencer with registered pin and status outputs. Stimulus is loaded on entry to SETUP
    // (DUT clock low), the clock rises in PULSE, and responses are folded on leaving CAPTURE,
    // so stimulus never changes near a DUT clock edge.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            dut_in  <= DUT_IN_RST;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            pat_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= SETUP;
                        // The LFSR is loaded on this same edge, so drive the seed directly.
                        dut_in  <= stim_word(SEED_EFF, 1'b0);
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        pat_cnt <= 8'h00;
                    end
                end
                SETUP: begin
                    state          <= PULSE;
                    dut_in[DUT_CK] <= 1'b1;
                end
                PULSE: begin
                    state          <= CAPTURE;
                    dut_in[DUT_CK] <= 1'b0;
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + 8'd1;
                    if (pat_cnt == LAST_IDX) begin
                        state  <= DONE;
                        dut_in <= DUT_IN_RST;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        // Signature is frozen in DONE, so judging the incoming value is exact.
                        pass   <= (misr_nx == GOLDEN_SIG);
                    end else begin
                        state  <= SETUP;
                        // LFSR advances on this edge; present its new value.
                        dut_in <= stim_word(lfsr_nx, 1'b0);
                    end
                end
                default: begin
                    state  <= IDLE;
                    dut_in <= DUT_IN_RST;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    pass   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iscas_bist_driver.sv
// Self-checking bench for iscas_bist_driver: table-driven single-pattern runs, hand sequences for
// multi-cycle corners, and a long randomized run checked against a spec-level model.
module tb_iscas_bist_driver;

    logic CK  = 1'b0;
    logic RST = 1'b1;

    // A: N=1, seed 01, golden 3F
    logic       start_a = 1'b0;
    logic [7:0] dout_a  = 8'h00;
    logic [7:0] din_a, sig_a, cnt_a;
    logic       busy_a, done_a, pass_a;
    // B: N=2, seed 01
    logic       start_b = 1'b0;
    logic [7:0] dout_b  = 8'h00;
    logic [7:0] din_b, sig_b, cnt_b;
    logic       busy_b, done_b, pass_b;
    // C: N=7, seed 00
    logic       start_c = 1'b0;
    logic [7:0] dout_c  = 8'h00;
    logic [7:0] din_c, sig_c, cnt_c;
    logic       busy_c, done_c, pass_c;
    // D: N=255, seed A5, golden 00
    logic       start_d = 1'b0;
    logic [7:0] dout_d  = 8'h00;
    logic [7:0] din_d, sig_d, cnt_d;
    logic       busy_d, done_d, pass_d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CK = ~CK;

    iscas_bist_driver #(.N_PATTERNS(1), .LFSR_SEED(8'h01), .GOLDEN_SIG(8'h3F)) u_a (
        .CK(CK), .RST(RST), .start(start_a), .dut_out(dout_a), .dut_in(din_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a));
    iscas_bist_driver #(.N_PATTERNS(2), .LFSR_SEED(8'h01), .GOLDEN_SIG(8'h00)) u_b (
        .CK(CK), .RST(RST), .start(start_b), .dut_out(dout_b), .dut_in(din_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b));
    iscas_bist_driver #(.N_PATTERNS(7), .LFSR_SEED(8'h00), .GOLDEN_SIG(8'h00)) u_c (
        .CK(CK), .RST(RST), .start(start_c), .dut_out(dout_c), .dut_in(din_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .signature(sig_c), .pat_cnt(cnt_c));
    iscas_bist_driver #(.N_PATTERNS(255), .LFSR_SEED(8'hA5), .GOLDEN_SIG(8'h00)) u_d (
        .CK(CK), .RST(RST), .start(start_d), .dut_out(dout_d), .dut_in(din_d), .busy(busy_d),
        .done(done_d), .pass(pass_d), .signature(sig_d), .pat_cnt(cnt_d));

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Spec-level step rules.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic fb;
        fb = l[7] ^ l[5] ^ l[4] ^ l[3];
        return 8'((l << 1) | {7'd0, fb});
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return 8'((s << 1) | {7'd0, fb}) ^ (r & 8'h3F);
    endfunction

    // Expected io_in: VDD high, GND low, G2..G0 = low LFSR bits, DUT clock in bit 0.
    function automatic logic [7:0] pins(input logic [7:0] l, input logic ck);
        return 8'h20 | {4'h0, l[2:0], ck};
    endfunction

    typedef struct {
        logic [7:0] resp;
        logic [7:0] sig;
        logic       pass;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [7:0]  exp_b[6];
        logic [7:0]  m_sig;
        logic [7:0]  m_lfsr;
        logic [7:0]  resp;
        int          edges;

        tbl[0] = '{resp: 8'h3F, sig: 8'h3F, pass: 1'b1};
        tbl[1] = '{resp: 8'h3E, sig: 8'h3E, pass: 1'b0};
        tbl[2] = '{resp: 8'hFF, sig: 8'h3F, pass: 1'b1};
        tbl[3] = '{resp: 8'hC0, sig: 8'h00, pass: 1'b0};
        tbl[4] = '{resp: 8'h7F, sig: 8'h3F, pass: 1'b1};

        // ---- reset state
        tick();
        tick();
        chk8("rst_din", din_a, 8'h20);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_pass", pass_a, 1'b0);
        chk8("rst_sig", sig_a, 8'h00);
        chk8("rst_cnt", cnt_a, 8'h00);
        chk8("rst_din_d", din_d, 8'h20);
        RST = 1'b0;
        tick();
        chk1("idle_busy", busy_a, 1'b0);

        // ---- A: single-pattern runs from a table; every run after the first starts from DONE
        for (int i = 0; i < 5; i++) begin
            dout_a  = tbl[i].resp;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk8($sformatf("a%0d_setup_din", i), din_a, 8'h22);
            chk1($sformatf("a%0d_busy", i), busy_a, 1'b1);
            chk1($sformatf("a%0d_done_lo", i), done_a, 1'b0);
            tick();
            chk8($sformatf("a%0d_pulse_din", i), din_a, 8'h23);
            tick();
            chk8($sformatf("a%0d_capt_din", i), din_a, 8'h22);
            chk8($sformatf("a%0d_capt_cnt", i), cnt_a, 8'h00);
            tick();
            chk1($sformatf("a%0d_done", i), done_a, 1'b1);
            chk1($sformatf("a%0d_busy_lo", i), busy_a, 1'b0);
            chk8($sformatf("a%0d_sig", i), sig_a, tbl[i].sig);
            chk1($sformatf("a%0d_pass", i), pass_a, tbl[i].pass);
            chk8($sformatf("a%0d_cnt", i), cnt_a, 8'h01);
            tick();
            chk1($sformatf("a%0d_done_hold", i), done_a, 1'b1);
            chk8($sformatf("a%0d_sig_hold", i), sig_a, tbl[i].sig);
        end

        // ---- B: two patterns, second stimulus from lfsr=02, done six edges after start
        exp_b[0] = 8'h23; exp_b[1] = 8'h22; exp_b[2] = 8'h24;
        exp_b[3] = 8'h25; exp_b[4] = 8'h24; exp_b[5] = 8'h20;
        dout_b  = 8'h05;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk8("b_setup0_din", din_b, 8'h22);
        chk8("b_cnt0", cnt_b, 8'h00);
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk8($sformatf("b_e%0d_din", e), din_b, exp_b[e-1]);
            chk1($sformatf("b_e%0d_done", e), done_b, (e == 6));
            if (e == 3) chk8("b_cnt1", cnt_b, 8'h01);
        end
        chk8("b_cnt2", cnt_b, 8'h02);
        m_sig = misr_step(misr_step(8'h00, 8'h05), 8'h05);
        chk8("b_sig", sig_b, m_sig);
        chk1("b_pass", pass_b, (m_sig == 8'h00));

        // ---- C: seed 00 acts as 01; start during PULSE is ignored
        dout_c  = 8'h2B;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        edges   = 1;
        chk8("c_seed0_din", din_c, 8'h22);
        tick();
        edges++;
        chk8("c_pulse_din", din_c, 8'h23);
        start_c = 1'b1;
        tick();
        edges++;
        start_c = 1'b0;
        chk1("c_busy_after_ign", busy_c, 1'b1);
        while (!done_c && edges < 60) begin
            tick();
            edges++;
        end
        chk1("c_done_in_time", done_c, 1'b1);
        chk8("c_run_edges", 8'(edges - 1), 8'd21);
        m_sig = 8'h00;
        for (int p = 0; p < 7; p++) m_sig = misr_step(m_sig, 8'h2B);
        chk8("c_sig", sig_c, m_sig);
        chk8("c_cnt", cnt_c, 8'd7);

        // ---- C: RST during CAPTURE of pattern 5 aborts the run
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int e = 0; e < 14; e++) tick();
        chk8("c_cnt_before_rst", cnt_c, 8'd4);
        chk1("c_busy_before_rst", busy_c, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk8("c_rst_din", din_c, 8'h20);
        chk1("c_rst_busy", busy_c, 1'b0);
        chk8("c_rst_sig", sig_c, 8'h00);
        chk8("c_rst_cnt", cnt_c, 8'h00);
        chk1("c_rst_done", done_c, 1'b0);
        // RST and start together: reset wins and the block stays idle
        RST     = 1'b1;
        start_c = 1'b1;
        tick();
        RST     = 1'b0;
        start_c = 1'b0;
        chk1("c_rst_start_busy", busy_c, 1'b0);
        tick();
        chk1("c_idle_busy", busy_c, 1'b0);
        chk8("c_idle_din", din_c, 8'h20);

        // ---- D: 255 patterns with random responses against the model
        m_lfsr  = 8'hA5;
        m_sig   = 8'h00;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int p = 0; p < 255; p++) begin
            chk8($sformatf("d_p%0d_setup", p), din_d, pins(m_lfsr, 1'b0));
            chk8($sformatf("d_p%0d_cnt", p), cnt_d, 8'(p));
            resp   = 8'($urandom);
            dout_d = resp;
            tick();
            chk8($sformatf("d_p%0d_pulse", p), din_d, pins(m_lfsr, 1'b1));
            tick();
            tick();
            m_sig  = misr_step(m_sig, resp);
            m_lfsr = lfsr_step(m_lfsr);
        end
        chk1("d_done", done_d, 1'b1);
        chk8("d_sig", sig_d, m_sig);
        chk1("d_pass", pass_d, (m_sig == 8'h00));
        chk8("d_cnt", cnt_d, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
